// File: rtl/pc_alu_srcb_mux_pkg.sv
// Shared encodings for the PC-update datapath slice.
// Also used by the main datapath ALU.
package pc_alu_srcb_mux_pkg;

  localparam int unsigned WIDTH_DEFAULT = 16;

  typedef enum logic {
    ALU_ADD = 1'b0,
    ALU_SUB = 1'b1
  } alu_op_e;

  typedef enum logic [1:0] {
    SRCB_SEL_A    = 2'd0,
    SRCB_SEL_B    = 2'd1,
    SRCB_SEL_C    = 2'd2,
    SRCB_SEL_ZERO = 2'd3
  } srcb_sel_e;

endpackage

// File: rtl/pc_alu_srcb_mux_alu.sv
// Two-function ALU (add / subtract) with zero flag.
// Carry and borrow are discarded; results wrap modulo 2^WIDTH.
module pc_alu
  import pc_alu_srcb_mux_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  alu_op_e          op_i,
  output logic [WIDTH-1:0] y_o,
  output logic             zero_o
);

  always_comb begin
    y_o = '0;
    unique case (op_i)
      ALU_ADD: y_o = a_i + b_i;
      ALU_SUB: y_o = a_i - b_i;
      default: y_o = '0;
    endcase
  end

  always_comb begin
    zero_o = ~|y_o;
  end

endmodule

// File: rtl/pc_alu_srcb_mux.sv
// Fetch-stage PC update: source-B mux feeding an add/sub ALU whose A operand
// is the PC; the ALU result is loaded into the PC when enabled.
module pc_alu_srcb_mux
  import pc_alu_srcb_mux_pkg::*;
#(
  parameter int unsigned      WIDTH    = WIDTH_DEFAULT,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             pc_en,
  input  logic             alu_op,
  input  logic [1:0]       srcb_sel,
  input  logic [WIDTH-1:0] srcb_a,
  input  logic [WIDTH-1:0] srcb_b,
  input  logic [WIDTH-1:0] srcb_c,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] src_b,
  output logic [WIDTH-1:0] alu_out,
  output logic             zero
);

  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] pc_d;

  // Select 3 is a hard zero so the ALU passes the PC through unchanged.
  always_comb begin
    src_b = '0;
    unique case (srcb_sel_e'(srcb_sel))
      SRCB_SEL_A:    src_b = srcb_a;
      SRCB_SEL_B:    src_b = srcb_b;
      SRCB_SEL_C:    src_b = srcb_c;
      SRCB_SEL_ZERO: src_b = '0;
      default:       src_b = '0;
    endcase
  end

  pc_alu #(
    .WIDTH(WIDTH)
  ) u_alu (
    .a_i    (pc_q),
    .b_i    (src_b),
    .op_i   (alu_op_e'(alu_op)),
    .y_o    (alu_out),
    .zero_o (zero)
  );

  always_comb begin
    pc_d = pc_q;
    if (pc_en) begin
      pc_d = alu_out;
    end
  end

  // Reset takes priority over a pending load.
  always_ff @(posedge clock) begin
    if (!reset) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: tb/tb_pc_alu_srcb_mux.sv
// Scoreboard bench for pc_alu_srcb_mux: directed scenarios then random traffic,
// checked against an arithmetic reference of the PC update rules.
module tb_pc_alu_srcb_mux;

  localparam int unsigned W = 16;
  localparam int unsigned MOD = 65536;
  localparam logic [W-1:0] RST_PC = 16'h0000;

  logic         clock;
  logic         reset;
  logic         pc_en;
  logic         alu_op;
  logic [1:0]   srcb_sel;
  logic [W-1:0] srcb_a, srcb_b, srcb_c;
  logic [W-1:0] pc, src_b, alu_out;
  logic         zero;

  pc_alu_srcb_mux #(
    .WIDTH    (W),
    .RESET_PC (RST_PC)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .pc_en    (pc_en),
    .alu_op   (alu_op),
    .srcb_sel (srcb_sel),
    .srcb_a   (srcb_a),
    .srcb_b   (srcb_b),
    .srcb_c   (srcb_c),
    .pc       (pc),
    .src_b    (src_b),
    .alu_out  (alu_out),
    .zero     (zero)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [W-1:0] pc;
    logic [W-1:0] srcb;
    logic [W-1:0] alu;
    logic         z;
  } exp_t;

  exp_t        sb_q[$];
  int unsigned model_pc;
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: outputs are stable mid-cycle, compare against queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("pc", pc, e.pc);
        chk("src_b", src_b, e.srcb);
        chk("alu_out", alu_out, e.alu);
        chk("zero", {{(W-1){1'b0}}, zero}, {{(W-1){1'b0}}, e.z});
      end
    end
  end

  // Apply one cycle of stimulus, queue the expected view, then advance the model.
  task automatic step(input logic rst, input logic en, input logic op, input logic [1:0] sel,
                      input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c);
    exp_t e;
    int unsigned opb, res;
    reset = rst; pc_en = en; alu_op = op; srcb_sel = sel;
    srcb_a = a; srcb_b = b; srcb_c = c;
    if (sel == 2'd0)      opb = a;
    else if (sel == 2'd1) opb = b;
    else if (sel == 2'd2) opb = c;
    else                  opb = 0;
    if (op) res = (model_pc + MOD - opb) % MOD;
    else    res = (model_pc + opb) % MOD;
    e.pc = W'(model_pc); e.srcb = W'(opb); e.alu = W'(res); e.z = (res == 0);
    sb_q.push_back(e);
    @(posedge clock);
    if (!rst)    model_pc = RST_PC;
    else if (en) model_pc = res;
    #1;
  endtask

  // Load an absolute PC value via the srcb_c path.
  task automatic load_pc(input int unsigned target);
    step(1'b1, 1'b1, 1'b0, 2'd2, 16'd2, 16'd0, W'((target + MOD - model_pc) % MOD));
  endtask

  initial begin
    // Power-up: pc unknown until the first reset edge, so nothing is queued.
    reset = 1'b0; pc_en = 1'b1; alu_op = 1'b0; srcb_sel = 2'd0;
    srcb_a = 16'd2; srcb_b = 16'd0; srcb_c = 16'd0;
    @(posedge clock);
    model_pc = RST_PC;
    #1;

    // Reset held with pc_en=1 and a nonzero offset.
    step(1'b0, 1'b1, 1'b0, 2'd2, 16'd2, 16'd0, 16'h1234);
    // Increment by 2 up to 8, hold three cycles, then continue to 16.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 2'd0, 16'd2, 16'd0, 16'd0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 2'd0, 16'd2, 16'd0, 16'd0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 2'd0, 16'd2, 16'd0, 16'd0);
    // Subtract via select 1, then select 3 yields zero operand.
    step(1'b1, 1'b1, 1'b1, 2'd1, 16'd2, 16'd6, 16'd0);
    step(1'b1, 1'b0, 1'b0, 2'd3, 16'd2, 16'd6, 16'd9);
    step(1'b1, 1'b0, 1'b1, 2'd3, 16'd2, 16'd6, 16'd9);
    // Wrap through zero and back.
    load_pc(32'hFFFE);
    step(1'b1, 1'b1, 1'b0, 2'd0, 16'd2, 16'd0, 16'd0);
    step(1'b1, 1'b1, 1'b1, 2'd0, 16'd2, 16'd0, 16'd0);
    step(1'b1, 1'b0, 1'b0, 2'd0, 16'd2, 16'd0, 16'd0);
    // Reset wins over a load; first load after release.
    load_pc(32'h0040);
    step(1'b0, 1'b1, 1'b0, 2'd0, 16'd2, 16'd0, 16'd0);
    step(1'b1, 1'b1, 1'b0, 2'd0, 16'd2, 16'd0, 16'd0);
    step(1'b1, 1'b0, 1'b0, 2'd0, 16'd2, 16'd0, 16'd0);

    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 15) != 0), 1'($urandom), 1'($urandom), 2'($urandom),
           ($urandom_range(0, 3) == 0) ? W'($urandom) : W'($urandom_range(0, 8)),
           W'($urandom), W'($urandom));
    end
    step(1'b1, 1'b0, 1'b0, 2'd3, 16'd0, 16'd0, 16'd0);

    // Bounded drain of the scoreboard.
    for (int i = 0; i < 5 && sb_q.size() > 0; i++) @(negedge clock);
    #1;
    if (sb_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
